countdown_timer: RTL and testbench
==================================

# countdown_timer

BCD minutes:seconds countdown timer for the digital clock's timer mode. It is the subtracting counterpart of the clock's add/carry time path. A valid MM:SS value is loaded, then decremented once per 1 Hz `tick` with BCD borrow propagation across digits. At zero it raises a one-cycle `expired` pulse and holds `alarm` for a bounded number of ticks. It sits beside the timekeeping counter and drives the display mux and buzzer.

## Interface
- `ALARM_TICKS`, default 10: number of `tick` pulses `alarm` stays high after expiry. Legal range is 1..255.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `tick`  in  1  1 Hz enable, one `clk` wide, synchronous to `clk`
- `load`  in  1  load request pulse
- `load_val`  in  16  BCD value {min_t, min_o, sec_t, sec_o}, 4 bits each
- `start`  in  1  start/resume pulse
- `pause`  in  1  pause pulse; also acknowledges the alarm
- `digits`  out  16  current BCD count, same packing as `load_val`
- `running`  out  1  high while in RUN
- `expired`  out  1  one-cycle pulse when the count reaches 00:00
- `alarm`  out  1  high while in ALARM
- `load_err`  out  1  one-cycle pulse when a load is rejected

## Operation
- **States:** IDLE, RUN, PAUSE, ALARM.
- **Reset values:** state IDLE; `digits` = 16'h0000; `running`, `expired`, `alarm`, `load_err` all 0; alarm tick counter 0.
- **Load validity:** `min_t` ≤ 5, `min_o` ≤ 9, `sec_t` ≤ 5, `sec_o` ≤ 9. Maximum value is 59:59.
- **Load acceptance:** `load` is honoured in IDLE, PAUSE and ALARM, and ignored in RUN (no `load_err`).
  - Valid load: `digits` ← `load_val`.
  - Valid load in ALARM: state → IDLE.
  - Valid load in PAUSE: state stays PAUSE.
  - Invalid load: `digits` unchanged, state unchanged, `load_err` = 1 for one cycle.
- **Start:** in IDLE or PAUSE, `start` with `digits` ≠ 0 moves to RUN. With `digits` = 0 it does nothing. `start` is ignored in RUN and ALARM.
- **Pause:** in RUN, `pause` moves to PAUSE. In ALARM, `pause` moves to IDLE (acknowledge). Ignored elsewhere.
- **Same-cycle priority:**
  - IDLE/PAUSE: `load` > `pause` > `start`. A cycle with `load` ignores `start` even if the load is valid.
  - RUN: `pause` > `tick`. A tick coincident with `pause` is dropped (no decrement).
- **Decrement:** in RUN, each `tick` subtracts one second with a BCD borrow chain.
  - `sec_o`: 0→9, borrow; else −1.
  - `sec_t`: on borrow, 0→5 and borrow; else −1.
  - `min_o`: on borrow, 0→9 and borrow; else −1.
  - `min_t`: on borrow, −1.
  - Underflow below 00:00 never occurs, because RUN is never entered at zero.
- **Expiry:** the tick that takes `digits` from 00:01 to 00:00 also moves state to ALARM, pulses `expired`, and clears the alarm tick counter.
- **ALARM:** each `tick` increments the counter. When ALARM_TICKS ticks have been counted, state → IDLE and `alarm` drops. `pause` or a valid `load` exits ALARM early. `digits` hold 0 in ALARM.

## Timing
- All outputs are registered. Every effect appears on the `clk` edge that samples the input high (1-cycle latency).
- `running` and `alarm` are state decodes, registered with the state.
- `expired` is high exactly one cycle, on the same edge where `digits` becomes 0 and `alarm` rises.
- `load_err` is high exactly one cycle per rejected load.
- `tick` held high for N cycles counts as N ticks; the block does no edge detection.
- `rst_n` assertion mid-count or mid-alarm forces reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- Reset mid-RUN at 12:34: all outputs 0 and state IDLE immediately; after release, `start` does nothing because `digits` = 0.
- Load 16'h0102, `start`, 3 ticks: `digits` goes 01:01 → 01:00 → 00:59. The third tick also asserts `expired` 0, `running` 1.
- Load 16'h1000, `start`, 1 tick: `digits` = 16'h0959, showing the full borrow chain.
- Load 16'h0001 with ALARM_TICKS = 3, `start`, 1 tick:
  - `digits` = 0, `expired` pulses once, `alarm` = 1.
  - After 3 more ticks, `alarm` = 0 and state IDLE.
  - Repeat the sequence with `pause` after 1 alarm tick: `alarm` drops on the next edge.
- Invalid loads 16'h0A00 and 16'h0060: each gives a `load_err` pulse and leaves `digits` unchanged.
  - `load` 16'h0500 during RUN: ignored, with no `load_err`.
- In RUN at 00:10, `pause` and `tick` in the same cycle: state PAUSE, `digits` stays 00:10. Then `start`: state RUN, and the next tick gives 00:09.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer: load, start/pause, 1 Hz decrement with borrow,
// then a bounded alarm phase after the count reaches 00:00.
module countdown_timer #(
   parameter int unsigned ALARM_TICKS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        start,
   input  logic        pause,
   output logic [15:0] digits,
   output logic        running,
   output logic        expired,
   output logic        alarm,
   output logic        load_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      ALARM = 2'd3
   } state_t;

   localparam logic [7:0] LAST_TICK = 8'(ALARM_TICKS - 1);

   state_t      state, state_next;
   logic [15:0] digits_next;
   logic [15:0] digits_dec;
   logic [7:0]  alarm_cnt, alarm_cnt_next;
   logic        expired_next;
   logic        load_err_next;
   logic        load_valid;

   assign load_valid = (load_val[15:12] <= 4'd5) && (load_val[11:8] <= 4'd9) &&
                       (load_val[7:4]   <= 4'd5) && (load_val[3:0]  <= 4'd9);

   // One-second BCD subtract; each digit only moves when everything below it wraps.
   always_comb begin
      digits_dec = digits;
      if (digits[3:0] != 4'd0) begin
         digits_dec[3:0] = digits[3:0] - 4'd1;
      end else begin
         digits_dec[3:0] = 4'd9;
         if (digits[7:4] != 4'd0) begin
            digits_dec[7:4] = digits[7:4] - 4'd1;
         end else begin
            digits_dec[7:4] = 4'd5;
            if (digits[11:8] != 4'd0) begin
               digits_dec[11:8] = digits[11:8] - 4'd1;
            end else begin
               digits_dec[11:8]  = 4'd9;
               digits_dec[15:12] = digits[15:12] - 4'd1;
            end
         end
      end
   end

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_next     = state;
      digits_next    = digits;
      alarm_cnt_next = alarm_cnt;
      expired_next   = 1'b0;
      load_err_next  = 1'b0;

      unique case (state)
         IDLE, PAUSE: begin
            if (load) begin
               if (load_valid) digits_next = load_val;
               else            load_err_next = 1'b1;
            end else if (pause) begin
               state_next = state;
            end else if (start && (digits != 16'h0000)) begin
               state_next = RUN;
            end
         end

         RUN: begin
            if (pause) begin
               state_next = PAUSE;
            end else if (tick) begin
               digits_next = digits_dec;
               if (digits == 16'h0001) begin
                  state_next     = ALARM;
                  expired_next   = 1'b1;
                  alarm_cnt_next = 8'd0;
               end
            end
         end

         ALARM: begin
            if (load) begin
               if (load_valid) begin
                  digits_next = load_val;
                  state_next  = IDLE;
               end else begin
                  load_err_next = 1'b1;
               end
            end else if (pause) begin
               state_next = IDLE;
            end else if (tick) begin
               if (alarm_cnt == LAST_TICK) state_next = IDLE;
               else                        alarm_cnt_next = alarm_cnt + 8'd1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops
   // update together from the values computed above.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         digits    <= 16'h0000;
         alarm_cnt <= 8'd0;
         expired   <= 1'b0;
         load_err  <= 1'b0;
         running   <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         state     <= state_next;
         digits    <= digits_next;
         alarm_cnt <= alarm_cnt_next;
         expired   <= expired_next;
         load_err  <= load_err_next;
         running   <= (state_next == RUN);
         alarm     <= (state_next == ALARM);
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// traffic compared against a seconds-based reference model.
module tb_countdown_timer;

   localparam int AT = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick, load, start, pause;
   logic [15:0] load_val;
   logic [15:0] digits;
   logic        running, expired, alarm, load_err;

   int n_chk = 0;
   int n_err = 0;

   int m_secs, m_mode, m_cnt;
   bit m_exp, m_lerr;

   countdown_timer #(.ALARM_TICKS(AT)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .digits(digits), .running(running),
      .expired(expired), .alarm(alarm), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_valid(input logic [15:0] v);
      return (v[15:12] <= 5) && (v[11:8] <= 9) && (v[7:4] <= 5) && (v[3:0] <= 9);
   endfunction

   function automatic int to_secs(input logic [15:0] v);
      return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(input int s);
      int m, r;
      m = s / 60;
      r = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_mode = M_IDLE; m_cnt = 0; m_exp = 0; m_lerr = 0;
   endtask

   task automatic model_step(input bit t, l, input logic [15:0] lv, input bit s, p);
      m_exp = 0;
      m_lerr = 0;
      case (m_mode)
         M_IDLE, M_PAUSE: begin
            if (l) begin
               if (is_valid(lv)) m_secs = to_secs(lv);
               else              m_lerr = 1;
            end else if (!p && s && m_secs != 0) begin
               m_mode = M_RUN;
            end
         end
         M_RUN: begin
            if (p) m_mode = M_PAUSE;
            else if (t) begin
               m_secs--;
               if (m_secs == 0) begin
                  m_mode = M_ALARM; m_exp = 1; m_cnt = 0;
               end
            end
         end
         default: begin
            if (l) begin
               if (is_valid(lv)) begin
                  m_secs = to_secs(lv); m_mode = M_IDLE;
               end else m_lerr = 1;
            end else if (p) m_mode = M_IDLE;
            else if (t) begin
               m_cnt++;
               if (m_cnt == AT) m_mode = M_IDLE;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check("digits",   digits,          to_bcd(m_secs));
      check("running",  16'(running),    16'(m_mode == M_RUN));
      check("alarm",    16'(alarm),      16'(m_mode == M_ALARM));
      check("expired",  16'(expired),    16'(m_exp));
      check("load_err", 16'(load_err),   16'(m_lerr));
   endtask

   task automatic cyc(input bit t, l, input logic [15:0] lv, input bit s, p);
      tick = t; load = l; load_val = lv; start = s; pause = p;
      model_step(t, l, lv, s, p);
      @(posedge clk);
      #1;
      tick = 0; load = 0; start = 0; pause = 0;
      compare_all();
   endtask

   initial begin
      logic [15:0] lv;
      rst_n = 0; tick = 0; load = 0; start = 0; pause = 0; load_val = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk); #1;
      compare_all();

      // 01:02 down three ticks to 00:59
      cyc(0, 1, 16'h0102, 0, 0);
      cyc(0, 0, 16'h0, 1, 0);
      repeat (3) cyc(1, 0, 16'h0, 0, 0);
      check("dec_0059", digits, 16'h0059);
      check("dec_noexp", 16'(expired), 16'd0);
      check("dec_run", 16'(running), 16'd1);

      // full borrow chain from 10:00
      cyc(0, 0, 16'h0, 0, 1);
      cyc(0, 1, 16'h1000, 0, 0);
      cyc(0, 0, 16'h0, 1, 0);
      cyc(1, 0, 16'h0, 0, 0);
      check("borrow", digits, 16'h0959);

      // expiry and alarm timeout
      cyc(0, 0, 16'h0, 0, 1);
      cyc(0, 1, 16'h0001, 0, 0);
      cyc(0, 0, 16'h0, 1, 0);
      cyc(1, 0, 16'h0, 0, 0);
      check("exp_digits", digits, 16'h0000);
      check("exp_pulse", 16'(expired), 16'd1);
      check("exp_alarm", 16'(alarm), 16'd1);
      cyc(1, 0, 16'h0, 0, 0);
      check("exp_once", 16'(expired), 16'd0);
      cyc(1, 0, 16'h0, 0, 0);
      check("alarm_hold", 16'(alarm), 16'd1);
      cyc(1, 0, 16'h0, 0, 0);
      check("alarm_done", 16'(alarm), 16'd0);

      // alarm acknowledged early by pause
      cyc(0, 1, 16'h0001, 0, 0);
      cyc(0, 0, 16'h0, 1, 0);
      cyc(1, 0, 16'h0, 0, 0);
      cyc(1, 0, 16'h0, 0, 0);
      cyc(0, 0, 16'h0, 0, 1);
      check("ack_alarm", 16'(alarm), 16'd0);

      // rejected loads, then load ignored while running
      cyc(0, 1, 16'h0A00, 0, 0);
      check("bad_min", 16'(load_err), 16'd1);
      check("bad_min_dig", digits, 16'h0000);
      cyc(0, 1, 16'h0060, 0, 0);
      check("bad_sec", 16'(load_err), 16'd1);
      cyc(0, 1, 16'h0015, 0, 0);
      cyc(0, 0, 16'h0, 1, 0);
      cyc(0, 1, 16'h0500, 0, 0);
      check("run_load_err", 16'(load_err), 16'd0);
      check("run_load_dig", digits, 16'h0015);

      // pause beats a coincident tick
      repeat (5) cyc(1, 0, 16'h0, 0, 0);
      cyc(1, 0, 16'h0, 0, 1);
      check("pause_dig", digits, 16'h0010);
      check("pause_run", 16'(running), 16'd0);
      cyc(0, 0, 16'h0, 1, 0);
      check("resume", 16'(running), 16'd1);
      cyc(1, 0, 16'h0, 0, 0);
      check("resume_dec", digits, 16'h0009);

      // asynchronous reset while running at 12:34
      cyc(0, 0, 16'h0, 0, 1);
      cyc(0, 1, 16'h1234, 0, 0);
      cyc(0, 0, 16'h0, 1, 0);
      #2 rst_n = 0;
      #1;
      model_reset();
      check("rst_digits", digits, 16'h0000);
      check("rst_running", 16'(running), 16'd0);
      compare_all();
      #3 rst_n = 1;
      @(posedge clk); #1;
      cyc(0, 0, 16'h0, 1, 0);
      check("rst_start", 16'(running), 16'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) lv = 16'($urandom_range(0, 65535));
         else if ($urandom_range(0, 3) == 0) lv = to_bcd($urandom_range(0, 3599));
         else lv = to_bcd($urandom_range(0, 20));
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, lv,
             $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
